entity_table_ctrl: RTL and testbench
====================================

ENTITY_TABLE_CTRL -- requirements
Module: entity_table_ctrl

Interface
REQ-001 SHALL have parameter COMMIT_LINE, default 10'd480, counter_V value whose arrival triggers the frame commit.
REQ-002 SHALL have parameter NUM_REQ, default 3, number of requesters; only the value 3 is supported.
REQ-003 SHALL have port clk_in  input  1  the single clock for all state.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port counter_V  input  10  vertical pixel counter from the VGA timing block.
REQ-006 SHALL have port req_valid  input  3  per-requester write request.
REQ-007 SHALL have port req_slot  input  12  packed 3x4 target slot numbers, requester i at [4i+3:4i].
REQ-008 SHALL have port req_data  input  54  packed 3x18 entity words, requester i at [18i+17:18i].
REQ-009 SHALL have port req_ready  output  3  one-hot grant; acceptance occurs where valid&ready.
REQ-010 SHALL have ports entity_1..entity_6, entity_8_Flip and entity_9_Flip  output  14 each  active entity words: ID[13:10], orientation[9:8], tile[7:0].
REQ-011 SHALL have port entity_7_Array  output  18  active array-entity word.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse on every commit event.
REQ-013 SHALL have port slot_err  output  1  sticky flag set when a request names a bad slot.

Function
REQ-014 SHALL map slots 0..8 to entity_1..entity_6, entity_7_Array, entity_8_Flip and entity_9_Flip respectively; 14-bit slots SHALL store req_data[17:4] of the accepted word.
REQ-015 SHALL detect a commit event when the registered previous counter_V differs from counter_V and counter_V equals COMMIT_LINE.
REQ-016 SHALL use FSM states IDLE, GRANT and COMMIT.
REQ-017 In IDLE: if a commit is pending, the next state SHALL be COMMIT; else if any req_valid is set, the next state SHALL be GRANT with the round-robin winner latched; else the FSM SHALL stay in IDLE.
REQ-018 In GRANT, req_ready SHALL equal the winner's one-hot bit for exactly that cycle, the winner's data SHALL be written to the shadow table at the end of the cycle, and the next state SHALL be IDLE.
REQ-019 Throughput SHALL be at most one write per 2 cycles; a requester SHALL hold valid, slot and data stable until it sees ready.
REQ-020 Round-robin arbitration SHALL search from a pointer (reset value 0) upward modulo 3; after a grant to requester g, the pointer SHALL become (g+1) mod 3.
REQ-021 In COMMIT, all 9 shadow slots SHALL be copied to the active outputs in one cycle, frame_tick SHALL be 1, req_ready SHALL be 0, the pending flag SHALL clear, and the next state SHALL be IDLE.
REQ-022 A commit event arriving in any state SHALL set the pending flag, so no event is lost; a write in GRANT during the event cycle SHALL complete first and be included in the commit.
REQ-023 A commit SHALL take priority over requests waiting in IDLE.
REQ-024 Multiple writes to the same slot between commits SHALL resolve as last write wins.
REQ-025 A request with slot > 8 SHALL be granted and dropped without writing; slot_err SHALL be set and held until reset.
REQ-026 Active outputs SHALL change only in the cycle after COMMIT.

Reset
REQ-027 On reset low, the 14-bit slots (shadow and active) SHALL be 14'h3C00, the array slot SHALL be 18'h3C000, req_ready SHALL be 0, frame_tick SHALL be 0, slot_err SHALL be 0, the FSM SHALL be IDLE, the pointer SHALL be 0, the pending flag SHALL be 0, and previous counter_V SHALL be 0.
REQ-028 A reset mid-GRANT SHALL abort the write, and the table SHALL return to all-disabled.

Configuration
REQ-029 Macro ENTITY_TABLE_SHADOW_EN defined SHALL give the double-buffered behaviour described above.
REQ-030 With ENTITY_TABLE_SHADOW_EN undefined: no shadow table; GRANT SHALL write active outputs directly; COMMIT SHALL only pulse frame_tick; all other timing SHALL be unchanged.

Structure
REQ-031 Package entity_pkg SHALL hold NUM_SLOTS=9, ENTITY_W=14, ARRAY_W=18, ID_DISABLED=4'hF, the reset words and the FSM state encoding.
REQ-032 Sub-module rr_arbiter3 SHALL hold the round-robin search and pointer; all other logic SHALL stay in entity_table_ctrl.

Verification
REQ-033 After reset release: all entity outputs SHALL be 14'h3C00, entity_7_Array SHALL be 18'h3C000, and req_ready SHALL be 0.
REQ-034 Req0 slot 0 data 18'h0A5F0, then counter_V 479->480 -> entity_1 SHALL be 14'h0A5F, but only in the cycle after the frame_tick pulse.
REQ-035 All three valid continuously -> grants SHALL be issued in order 0,1,2,0 on every second cycle.
REQ-036 Commit event during GRANT of req2 (slot 6 data 18'h12345) -> entity_7_Array SHALL be 18'h12345 after COMMIT, which follows the GRANT by 2 cycles.
REQ-037 Req1 slot 4'd12 -> req_ready[1] SHALL pulse, no output SHALL change, and slot_err SHALL be 1 until reset.
REQ-038 Two writes to slot 3 (0x1111 then 0x2222 in [17:4]) before a commit -> entity_4 SHALL be 14'h2222.

Source files
------------

// File: rtl/entity_pkg.sv
// Shared constants, reset words and FSM encoding for the entity table controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package entity_pkg;

    localparam int NUM_SLOTS = 9;
    localparam int NUM_ENT   = NUM_SLOTS - 1;   // 14-bit slots; slot 6 is the 18-bit array slot
    localparam int ENTITY_W  = 14;
    localparam int ARRAY_W   = 18;

    localparam logic [3:0] ID_DISABLED = 4'hF;
    localparam logic [3:0] ARRAY_SLOT  = 4'd6;
    localparam logic [3:0] LAST_SLOT   = 4'd8;

    // A disabled entity carries ID 0xF and zero orientation/tile bits.
    localparam logic [ENTITY_W-1:0] ENTITY_RST = {ID_DISABLED, 10'h000};
    localparam logic [ARRAY_W-1:0]  ARRAY_RST  = {ID_DISABLED, 14'h0000};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Map a valid slot number (not the array slot) onto the packed 14-bit storage index.
    // Slots 0..5 map straight through; slots 7 and 8 close the gap left by the array slot.
    function automatic logic [2:0] ent_idx(input logic [3:0] slot);
        logic [2:0] idx;
        case (slot)
            4'd7:    idx = 3'd6;
            4'd8:    idx = 3'd7;
            default: idx = slot[2:0];
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin search starting at a rotating pointer.
// Latency: winner is combinational from req; pointer moves on the clock edge after an advance.
// Backpressure: pointer only moves when the caller accepts the winner (advance), so stalled requests keep their turn.
module rr_arbiter3
    import entity_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [1:0] win_idx,
    output logic       win_vld
);

    logic [1:0] ptr_q;
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] rr_pos(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    assign cand0 = rr_pos(ptr_q, 2'd0);
    assign cand1 = rr_pos(ptr_q, 2'd1);
    assign cand2 = rr_pos(ptr_q, 2'd2);

    // Pick the first requester at or above the pointer, wrapping modulo 3.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        if (req[cand0]) begin
            win_vld = 1'b1;
            win_idx = cand0;
        end else if (req[cand1]) begin
            win_vld = 1'b1;
            win_idx = cand1;
        end else if (req[cand2]) begin
            win_vld = 1'b1;
            win_idx = cand2;
        end
    end

    // After a grant, the requester just above the winner gets first look next time.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ptr_q <= 2'd0;
        end else if (advance && win_vld) begin
            ptr_q <= rr_pos(win_idx, 2'd1);
        end
    end

endmodule

// File: rtl/entity_table_ctrl.sv
// Arbitrates three writers into a 9-slot entity table and commits it to the display once per frame.
// Latency: grant one cycle after valid is seen in IDLE, write lands at end of GRANT, outputs update the cycle after COMMIT.
// Backpressure: single-cycle one-hot req_ready, at most one write per 2 cycles; a pending commit is served before new grants.
// Build option ENTITY_TABLE_SHADOW_EN: defined gives a shadow table copied out on commit; undefined writes the outputs directly.
module entity_table_ctrl
    import entity_pkg::*;
#(
    parameter logic [9:0] COMMIT_LINE = 10'd480,
    parameter int         NUM_REQ     = 3
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [9:0]             counter_V,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_slot,
    input  logic [18*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [ENTITY_W-1:0]    entity_1,
    output logic [ENTITY_W-1:0]    entity_2,
    output logic [ENTITY_W-1:0]    entity_3,
    output logic [ENTITY_W-1:0]    entity_4,
    output logic [ENTITY_W-1:0]    entity_5,
    output logic [ENTITY_W-1:0]    entity_6,
    output logic [ARRAY_W-1:0]     entity_7_Array,
    output logic [ENTITY_W-1:0]    entity_8_Flip,
    output logic [ENTITY_W-1:0]    entity_9_Flip,
    output logic                   frame_tick,
    output logic                   slot_err
);

    state_t               state_q;
    logic                 pending_q;
    logic [9:0]           prev_v_q;
    logic [3:0]           wr_slot_q;
    logic [ARRAY_W-1:0]   wr_dat_q;

    logic                 commit_evt;
    logic [1:0]           arb_idx;
    logic                 arb_vld;
    logic                 arb_advance;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [3:0]           sel_slot;
    logic [ARRAY_W-1:0]   sel_dat;
    logic                 slot_ok;
    logic                 tbl_wr;

    logic [ENTITY_W-1:0]  act_ent [NUM_ENT];
    logic [ARRAY_W-1:0]   act_arr;

    // A commit fires once, on the cycle counter_V first arrives at the commit line.
    assign commit_evt = (prev_v_q != counter_V) && (counter_V == COMMIT_LINE);

    // The arbiter pointer only moves when IDLE actually hands out a grant.
    assign arb_advance = (state_q == IDLE) && !pending_q;

    rr_arbiter3 u_arb (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (req_valid),
        .advance (arb_advance),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    // Steer the winning requester's slot and word onto the latch path.
    always_comb begin
        sel_slot = 4'd0;
        sel_dat  = '0;
        case (arb_idx)
            2'd0: begin
                sel_slot = req_slot[3:0];
                sel_dat  = req_data[17:0];
            end
            2'd1: begin
                sel_slot = req_slot[7:4];
                sel_dat  = req_data[35:18];
            end
            2'd2: begin
                sel_slot = req_slot[11:8];
                sel_dat  = req_data[53:36];
            end
            default: begin
                sel_slot = 4'd0;
                sel_dat  = '0;
            end
        endcase
    end

    // One-hot form of the winner, loaded into req_ready when GRANT is entered.
    always_comb begin
        arb_onehot          = '0;
        arb_onehot[arb_idx] = 1'b1;
    end

    // Out-of-range slots are still granted (so the requester can move on) but never written.
    assign slot_ok = (wr_slot_q <= LAST_SLOT);
    assign tbl_wr  = (state_q == GRANT) && slot_ok;

    // Control FSM: IDLE decides commit-vs-grant, GRANT writes one word, COMMIT publishes the frame.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            prev_v_q   <= 10'd0;
            wr_slot_q  <= 4'd0;
            wr_dat_q   <= '0;
            req_ready  <= '0;
            frame_tick <= 1'b0;
            slot_err   <= 1'b0;
        end else begin
            prev_v_q   <= counter_V;
            req_ready  <= '0;
            frame_tick <= 1'b0;
            // A new event wins over the clear, so an event landing in COMMIT is not lost.
            pending_q  <= commit_evt || (pending_q && (state_q != COMMIT));
            if ((state_q == GRANT) && !slot_ok) begin
                slot_err <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q    <= COMMIT;
                        frame_tick <= 1'b1;
                    end else if (arb_vld) begin
                        state_q   <= GRANT;
                        wr_slot_q <= sel_slot;
                        wr_dat_q  <= sel_dat;
                        req_ready <= arb_onehot;
                    end
                end
                GRANT: begin
                    state_q <= IDLE;
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ENTITY_TABLE_SHADOW_EN
    logic [ENTITY_W-1:0]  sh_ent [NUM_ENT];
    logic [ARRAY_W-1:0]   sh_arr;

    // Shadow table collects this frame's writes; last write to a slot wins.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                sh_ent[i] <= ENTITY_RST;
            end
            sh_arr <= ARRAY_RST;
        end else if (tbl_wr) begin
            if (wr_slot_q == ARRAY_SLOT) begin
                sh_arr <= wr_dat_q;
            end else begin
                sh_ent[ent_idx(wr_slot_q)] <= wr_dat_q[17:4];
            end
        end
    end

    // Active table copies the whole shadow in the COMMIT cycle, visible the cycle after.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                act_ent[i] <= ENTITY_RST;
            end
            act_arr <= ARRAY_RST;
        end else if (state_q == COMMIT) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                act_ent[i] <= sh_ent[i];
            end
            act_arr <= sh_arr;
        end
    end
`else
    // Without a shadow, each accepted write goes straight to the active outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                act_ent[i] <= ENTITY_RST;
            end
            act_arr <= ARRAY_RST;
        end else if (tbl_wr) begin
            if (wr_slot_q == ARRAY_SLOT) begin
                act_arr <= wr_dat_q;
            end else begin
                act_ent[ent_idx(wr_slot_q)] <= wr_dat_q[17:4];
            end
        end
    end
`endif

    assign entity_1       = act_ent[0];
    assign entity_2       = act_ent[1];
    assign entity_3       = act_ent[2];
    assign entity_4       = act_ent[3];
    assign entity_5       = act_ent[4];
    assign entity_6       = act_ent[5];
    assign entity_7_Array = act_arr;
    assign entity_8_Flip  = act_ent[6];
    assign entity_9_Flip  = act_ent[7];

endmodule

// File: tb/tb_entity_table_ctrl.sv
// Directed bench for entity_table_ctrl: reset state, round-robin order, commit timing, slot errors, reset abort.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold valid/slot/data until req_ready is seen, bounded by a cycle budget.
module tb_entity_table_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [9:0]  counter_V;
    logic [2:0]  req_valid;
    logic [11:0] req_slot;
    logic [53:0] req_data;
    logic [2:0]  req_ready;
    logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6;
    logic [17:0] entity_7_Array;
    logic [13:0] entity_8_Flip, entity_9_Flip;
    logic        frame_tick;
    logic        slot_err;

`ifdef ENTITY_TABLE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_rr [8];

    entity_table_ctrl #(.COMMIT_LINE(10'd480), .NUM_REQ(3)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .counter_V      (counter_V),
        .req_valid      (req_valid),
        .req_slot       (req_slot),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .entity_1       (entity_1),
        .entity_2       (entity_2),
        .entity_3       (entity_3),
        .entity_4       (entity_4),
        .entity_5       (entity_5),
        .entity_6       (entity_6),
        .entity_7_Array (entity_7_Array),
        .entity_8_Flip  (entity_8_Flip),
        .entity_9_Flip  (entity_9_Flip),
        .frame_tick     (frame_tick),
        .slot_err       (slot_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [17:0] d);
        req_valid[i]        = 1'b1;
        req_slot[i*4 +: 4]  = s;
        req_data[i*18 +: 18] = d;
    endtask

    // Raise a request and wait (bounded) until its ready is seen; returns inside the GRANT cycle.
    task automatic do_write(input int i, input logic [3:0] s, input logic [17:0] d, input string tag);
        bit seen;
        logic [2:0] exp_oh;
        seen = 1'b0;
        exp_oh = 3'b001 << i;
        set_req(i, s, d);
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            if (req_ready[i]) seen = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk(tag, {15'd0, req_ready}, {15'd0, exp_oh});
    endtask

    // Drive counter_V 479 -> 480 from IDLE and check the tick lands two cycles later.
    task automatic commit_seq(input string tag);
        counter_V = 10'd479;
        step();
        counter_V = 10'd480;
        step();
        step();
        chk({tag, "_tick"}, {17'd0, frame_tick}, 18'd1);
        chk({tag, "_tick_rdy"}, {15'd0, req_ready}, 18'd0);
        step();
        chk({tag, "_tick_end"}, {17'd0, frame_tick}, 18'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_rr = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        reset     = 1'b0;
        counter_V = 10'd0;
        req_valid = 3'b000;
        req_slot  = '0;
        req_data  = '0;
        repeat (3) step();

        // Reset state while held
        chk("rst_e1",   {4'd0, entity_1}, 18'h03C00);
        chk("rst_arr",  entity_7_Array, 18'h3C000);
        chk("rst_rdy",  {15'd0, req_ready}, 18'd0);
        chk("rst_tick", {17'd0, frame_tick}, 18'd0);
        chk("rst_err",  {17'd0, slot_err}, 18'd0);

        reset = 1'b1;
        step();
        chk("post_e4",  {4'd0, entity_4}, 18'h03C00);
        chk("post_e9",  {4'd0, entity_9_Flip}, 18'h03C00);
        chk("post_arr", entity_7_Array, 18'h3C000);
        chk("post_rdy", {15'd0, req_ready}, 18'd0);

        // All three requesters valid continuously: grants 0,1,2,0 every second cycle
        set_req(0, 4'd1, 18'h01110);
        set_req(1, 4'd2, 18'h02220);
        set_req(2, 4'd4, 18'h04440);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr_%0d", k), {15'd0, req_ready}, {15'd0, exp_rr[k]});
        end
        req_valid = 3'b000;
        chk("rr_e2", {4'd0, entity_2}, SHADOW ? 18'h03C00 : 18'h00111);
        chk("rr_e5", {4'd0, entity_5}, SHADOW ? 18'h03C00 : 18'h00444);

        // Req0 slot 0, then a commit: entity_1 shows the word only after the tick cycle
        do_write(0, 4'd0, 18'h0A5F0, "a_rdy");
        step();
        chk("a_pre", {4'd0, entity_1}, SHADOW ? 18'h03C00 : 18'h00A5F);
        counter_V = 10'd479;
        step();
        counter_V = 10'd480;
        step();
        chk("a_tick0", {17'd0, frame_tick}, 18'd0);
        step();
        chk("a_tick1", {17'd0, frame_tick}, 18'd1);
        chk("a_e1_in_tick", {4'd0, entity_1}, SHADOW ? 18'h03C00 : 18'h00A5F);
        step();
        chk("a_tick2", {17'd0, frame_tick}, 18'd0);
        chk("a_e1", {4'd0, entity_1}, 18'h00A5F);
        chk("a_e2", {4'd0, entity_2}, 18'h00111);
        chk("a_e3", {4'd0, entity_3}, 18'h00222);
        chk("a_e5", {4'd0, entity_5}, 18'h00444);
        chk("a_e4", {4'd0, entity_4}, 18'h03C00);

        // Two writes to slot 3 before a commit: last write wins
        do_write(1, 4'd3, 18'h11110, "c_rdy1");
        step();
        do_write(2, 4'd3, 18'h22220, "c_rdy2");
        step();
        chk("c_pre", {4'd0, entity_4}, SHADOW ? 18'h03C00 : 18'h02222);
        commit_seq("c");
        chk("c_e4", {4'd0, entity_4}, 18'h02222);

        // Commit event during GRANT of req2; req0 waiting in IDLE must yield to the commit
        counter_V = 10'd479;
        do_write(2, 4'd6, 18'h12345, "d_rdy");
        counter_V = 10'd480;
        set_req(0, 4'd8, 18'h3ABCD);
        step();
        chk("d_pre", entity_7_Array, SHADOW ? 18'h3C000 : 18'h12345);
        chk("d_idle_rdy", {15'd0, req_ready}, 18'd0);
        step();
        chk("d_tick", {17'd0, frame_tick}, 18'd1);
        chk("d_prio", {15'd0, req_ready}, 18'd0);
        step();
        chk("d_arr", entity_7_Array, 18'h12345);
        step();
        chk("d_grant0", {15'd0, req_ready}, 18'h00001);
        req_valid = 3'b000;
        step();
        chk("d_e9", {4'd0, entity_9_Flip}, SHADOW ? 18'h03C00 : 18'h03ABC);

        // Bad slot: granted, dropped, sticky error
        chk("e_err0", {17'd0, slot_err}, 18'd0);
        do_write(1, 4'd12, 18'h3FFF0, "e_rdy");
        step();
        chk("e_err1", {17'd0, slot_err}, 18'd1);
        chk("e_e2",   {4'd0, entity_2}, 18'h00111);
        chk("e_arr",  entity_7_Array, 18'h12345);
        commit_seq("e");
        chk("e_e9",   {4'd0, entity_9_Flip}, 18'h03ABC);
        chk("e_e1",   {4'd0, entity_1}, 18'h00A5F);
        chk("e_e4",   {4'd0, entity_4}, 18'h02222);
        chk("e_e8",   {4'd0, entity_8_Flip}, 18'h03C00);
        chk("e_err2", {17'd0, slot_err}, 18'd1);

        // Reset in the middle of a GRANT aborts the write and disables the table
        do_write(0, 4'd5, 18'h05550, "f_rdy");
        reset = 1'b0;
        #2;
        chk("f_e6",  {4'd0, entity_6}, 18'h03C00);
        chk("f_e1",  {4'd0, entity_1}, 18'h03C00);
        chk("f_arr", entity_7_Array, 18'h3C000);
        chk("f_err", {17'd0, slot_err}, 18'd0);
        chk("f_rdy0", {15'd0, req_ready}, 18'd0);
        step();
        reset = 1'b1;
        step();
        commit_seq("f");
        chk("f_e6b", {4'd0, entity_6}, 18'h03C00);
        chk("f_e4b", {4'd0, entity_4}, 18'h03C00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
